// File: rtl/multicycle_cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode encodings for both
// decoder flavours, FSM state codes, trap causes, ALU control values and instruction classes.
package multicycle_cu_pkg;

    localparam logic [6:0] OPC_ADD      = 7'b0110011;
    localparam logic [6:0] OPC_ADDI     = 7'b0010011;
    localparam logic [6:0] OPC_LW       = 7'b0000011;
    localparam logic [6:0] OPC_SW       = 7'b0100011;

    localparam logic [3:0] OPC_ADD_PMU  = 4'b0001;
    localparam logic [3:0] OPC_ADDI_PMU = 4'b0010;
    localparam logic [3:0] OPC_LW_PMU   = 4'b0011;
    localparam logic [3:0] OPC_SW_PMU   = 4'b0100;

    localparam logic [2:0] ALU_ADD      = 3'b000;
    localparam logic [2:0] ALU_NOP      = 3'b111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_IMEM    = 2'b10,
        CAUSE_DMEM    = 2'b11
    } cause_e;

    typedef enum logic [2:0] {
        CLS_ADD,
        CLS_ADDI,
        CLS_LW,
        CLS_SW,
        CLS_ILL
    } class_e;

    function automatic logic is_mem_class(input class_e c);
        return (c == CLS_LW) || (c == CLS_SW);
    endfunction

endpackage

// File: rtl/multicycle_cu_opcode_classifier.sv
// Combinational opcode classifier; one instance serves either the 7-bit RV32I
// or the 4-bit compact encoding, selected at elaboration by COMPACT.
module multicycle_cu_opcode_classifier
    import multicycle_cu_pkg::*;
#(
    parameter int COMPACT = 0,
    parameter int OPC_W   = 7
) (
    input  logic [OPC_W-1:0] i_opcode,
    output class_e           o_class
);

    generate
        if (COMPACT != 0) begin : g_compact
            always_comb begin
                case (i_opcode)
                    OPC_ADD_PMU:  o_class = CLS_ADD;
                    OPC_ADDI_PMU: o_class = CLS_ADDI;
                    OPC_LW_PMU:   o_class = CLS_LW;
                    OPC_SW_PMU:   o_class = CLS_SW;
                    default:      o_class = CLS_ILL;
                endcase
            end
        end else begin : g_rv32i
            always_comb begin
                case (i_opcode)
                    OPC_ADD:  o_class = CLS_ADD;
                    OPC_ADDI: o_class = CLS_ADDI;
                    OPC_LW:   o_class = CLS_LW;
                    OPC_SW:   o_class = CLS_SW;
                    default:  o_class = CLS_ILL;
                endcase
            end
        end
    endgenerate

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle control unit sequencing FETCH/DECODE/EXEC/MEM/WB for add, addi, lw, sw
// with req/ready memory handshakes, a wait-state timeout trap and a retired counter.
module multicycle_cu
    import multicycle_cu_pkg::*;
#(
    parameter int COMPACT  = 0,
    parameter int OPC_W    = 7,
    parameter int ALU_W    = 3,
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write_en,
    output logic             alu_src_imm,
    output logic             mem_to_reg,
    output logic [ALU_W-1:0] alu_ctl,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    localparam logic [ALU_W-1:0] L_ALU_ADD   = {ALU_W{ALU_ADD[0]}};
    localparam logic [ALU_W-1:0] L_ALU_NOP   = {ALU_W{ALU_NOP[0]}};
    localparam logic [7:0]       L_WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic             r_run;
    class_e           r_class;
    class_e           w_class;
    logic [7:0]       r_wait_cnt;
    logic             w_wait_last;
    logic             w_wait_inc;
    logic             w_retire;
    cause_e           w_cause;
    cause_e           r_trap_cause;
    logic [CNT_W-1:0] r_retired;

    multicycle_cu_opcode_classifier #(
        .COMPACT (COMPACT),
        .OPC_W   (OPC_W)
    ) u_classifier (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    assign w_wait_last = (r_wait_cnt == L_WAIT_LAST);

    // r_run keeps all outputs quiet during reset and for the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path can infer a latch.
        w_next_state = r_state;
        w_cause      = CAUSE_NONE;
        w_wait_inc   = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write_en = 1'b0;
        alu_src_imm  = 1'b0;
        mem_to_reg   = 1'b0;
        alu_ctl      = L_ALU_NOP;
        trap         = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (r_run) begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write     = 1'b1;
                        pc_write     = 1'b1;
                        w_next_state = ST_DECODE;
                    end else if (w_wait_last) begin
                        w_next_state = ST_TRAP;
                        w_cause      = CAUSE_IMEM;
                    end else begin
                        w_wait_inc = 1'b1;
                    end
                end
            end
            ST_DECODE: begin
                if (w_class == CLS_ILL) begin
                    w_next_state = ST_TRAP;
                    w_cause      = CAUSE_ILLEGAL;
                end else begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_ctl     = L_ALU_ADD;
                alu_src_imm = (r_class != CLS_ADD);
                if (is_mem_class(r_class)) begin
                    w_next_state = ST_MEM;
                end else begin
                    w_next_state = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_req    = 1'b1;
                dmem_we     = (r_class == CLS_SW);
                alu_ctl     = L_ALU_ADD;
                alu_src_imm = 1'b1;
                // Ready is tested before the timeout so a reply on the last allowed cycle still succeeds.
                if (dmem_ready) begin
                    if (r_class == CLS_SW) begin
                        w_retire     = 1'b1;
                        w_next_state = ST_FETCH;
                    end else begin
                        w_next_state = ST_WB;
                    end
                end else if (w_wait_last) begin
                    w_next_state = ST_TRAP;
                    w_cause      = CAUSE_DMEM;
                end else begin
                    w_wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                mem_to_reg   = (r_class == CLS_LW);
                alu_ctl      = L_ALU_ADD;
                alu_src_imm  = (r_class != CLS_ADD);
                w_retire     = 1'b1;
                w_next_state = ST_FETCH;
            end
            ST_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                w_next_state = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_class      <= CLS_ILL;
            r_wait_cnt   <= 8'd0;
            r_trap_cause <= CAUSE_NONE;
            r_retired    <= '0;
        end else begin
            // NOTE: non-blocking here so every register sees the pre-edge values of the others.
            r_wait_cnt <= w_wait_inc ? (r_wait_cnt + 8'd1) : 8'd0;
            if (r_state == ST_DECODE) begin
                r_class <= w_class;
            end
            if ((w_next_state == ST_TRAP) && (r_state != ST_TRAP)) begin
                r_trap_cause <= w_cause;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign trap_cause = r_trap_cause;
    assign retired    = r_retired;
    assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench: a transaction-level model expands each instruction (opcode, wait
// counts) into the expected per-cycle trace, which is compared against two DUT configurations.
module tb_multicycle_cu;
    import multicycle_cu_pkg::*;

    localparam int W0 = 4;
    localparam int W1 = 15;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, dreq, we, irw, pcw, rw, src, m2r;
        logic [2:0]  alu;
        logic        trp;
        logic [1:0]  cause;
        logic [15:0] ret;
    } obs_t;

    typedef struct {
        logic [6:0] opc;
        logic       ir;
        logic       dr;
        obs_t       exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n0, rst_n1;
    logic [6:0] opc;
    logic       imem_ready, dmem_ready;

    logic        imem_req_w[2], dmem_req_w[2], dmem_we_w[2], ir_write_w[2], pc_write_w[2];
    logic        rwe_w[2], src_w[2], m2r_w[2], trap_w[2];
    logic [2:0]  alu_w[2], st_w[2];
    logic [1:0]  cause_w[2];
    logic [15:0] ret0;
    logic [3:0]  ret1;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    m_dut = 0;
    int    m_ret = 0;
    int    m_mask = 32'hFFFF;
    step_t q[$];

    always #5 clk = ~clk;

    multicycle_cu #(.COMPACT(0), .OPC_W(7), .ALU_W(3), .WAIT_MAX(W0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n0), .opcode(opc), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req_w[0]), .dmem_req(dmem_req_w[0]), .dmem_we(dmem_we_w[0]),
        .ir_write(ir_write_w[0]), .pc_write(pc_write_w[0]), .reg_write_en(rwe_w[0]),
        .alu_src_imm(src_w[0]), .mem_to_reg(m2r_w[0]), .alu_ctl(alu_w[0]), .trap(trap_w[0]),
        .trap_cause(cause_w[0]), .retired(ret0), .state_o(st_w[0])
    );

    multicycle_cu #(.COMPACT(1), .OPC_W(4), .ALU_W(3), .WAIT_MAX(W1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .opcode(opc[3:0]), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req_w[1]), .dmem_req(dmem_req_w[1]), .dmem_we(dmem_we_w[1]),
        .ir_write(ir_write_w[1]), .pc_write(pc_write_w[1]), .reg_write_en(rwe_w[1]),
        .alu_src_imm(src_w[1]), .mem_to_reg(m2r_w[1]), .alu_ctl(alu_w[1]), .trap(trap_w[1]),
        .trap_cause(cause_w[1]), .retired(ret1), .state_o(st_w[1])
    );

    function automatic obs_t get_obs();
        obs_t o;
        int   d;
        d       = m_dut;
        o.st    = st_w[d];
        o.ireq  = imem_req_w[d];
        o.dreq  = dmem_req_w[d];
        o.we    = dmem_we_w[d];
        o.irw   = ir_write_w[d];
        o.pcw   = pc_write_w[d];
        o.rw    = rwe_w[d];
        o.src   = src_w[d];
        o.m2r   = m2r_w[d];
        o.alu   = alu_w[d];
        o.trp   = trap_w[d];
        o.cause = cause_w[d];
        o.ret   = (d == 0) ? ret0 : {12'd0, ret1};
        return o;
    endfunction

    task automatic check_obs(input string tag, input obs_t got, input obs_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc%0d: got=%h expected=%h", tag, m_dut, cyc, got, exp);
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s dut%0d: got=%0d expected=%0d", tag, m_dut, got, exp);
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [6:0] rnd_opc();
        return 7'($urandom);
    endfunction

    // 0 add, 1 addi, 2 lw, 3 sw, 4 illegal
    function automatic int classify(input logic [6:0] op);
        if (m_dut == 0) begin
            case (op)
                7'b0110011: return 0;
                7'b0010011: return 1;
                7'b0000011: return 2;
                7'b0100011: return 3;
                default:    return 4;
            endcase
        end
        case (op[3:0])
            OPC_ADD_PMU:  return 0;
            OPC_ADDI_PMU: return 1;
            OPC_LW_PMU:   return 2;
            OPC_SW_PMU:   return 3;
            default:      return 4;
        endcase
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.alu = 3'b111;
        o.ret = 16'(m_ret & m_mask);
        return o;
    endfunction

    task automatic push(input obs_t e, input logic ir, input logic dr, input logic [6:0] o);
        step_t s;
        s.opc = o;
        s.ir  = ir;
        s.dr  = dr;
        s.exp = e;
        q.push_back(s);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        obs_t e;
        for (int k = 0; k < 3; k++) begin
            e       = base(3'd7);
            e.trp   = 1'b1;
            e.cause = cause;
            push(e, 1'(k), rnd(), rnd_opc());
        end
    endtask

    // Expands one instruction into its expected cycle-by-cycle behaviour.
    task automatic model_instr(input logic [6:0] op, input int iw, input int dw, output bit trapped);
        obs_t e;
        int   w;
        int   cls;
        trapped = 1'b0;
        w   = (m_dut == 0) ? W0 : W1;
        cls = classify(op);
        for (int k = 0; k < ((iw >= w) ? w : iw); k++) begin
            e = base(3'd0); e.ireq = 1'b1;
            push(e, 1'b0, rnd(), rnd_opc());
        end
        if (iw >= w) begin
            push_trap(2'b10); trapped = 1'b1; return;
        end
        e = base(3'd0); e.ireq = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        push(e, 1'b1, rnd(), rnd_opc());
        e = base(3'd1);
        push(e, rnd(), rnd(), op);
        if (cls == 4) begin
            push_trap(2'b01); trapped = 1'b1; return;
        end
        e = base(3'd2); e.alu = 3'b000; e.src = (cls != 0);
        push(e, rnd(), rnd(), rnd_opc());
        if (cls >= 2) begin
            for (int k = 0; k < ((dw >= w) ? w : dw); k++) begin
                e = base(3'd3); e.dreq = 1'b1; e.we = (cls == 3); e.alu = 3'b000; e.src = 1'b1;
                push(e, rnd(), 1'b0, rnd_opc());
            end
            if (dw >= w) begin
                push_trap(2'b11); trapped = 1'b1; return;
            end
            e = base(3'd3); e.dreq = 1'b1; e.we = (cls == 3); e.alu = 3'b000; e.src = 1'b1;
            push(e, rnd(), 1'b1, rnd_opc());
            if (cls == 3) begin
                m_ret++; return;
            end
        end
        e = base(3'd4); e.rw = 1'b1; e.m2r = (cls == 2); e.alu = 3'b000; e.src = (cls != 0);
        push(e, rnd(), rnd(), rnd_opc());
        m_ret++;
    endtask

    task automatic run_n(input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            if (q.size() == 0) break;
            s = q.pop_front();
            @(posedge clk);
            #1;
            opc        = s.opc;
            imem_ready = s.ir;
            dmem_ready = s.dr;
            @(negedge clk);
            cyc++;
            check_obs("trace", get_obs(), s.exp);
        end
    endtask

    task automatic do_reset(input int d);
        obs_t e;
        @(negedge clk);
        rst_n0     = 1'b0;
        rst_n1     = 1'b0;
        m_dut      = d;
        m_ret      = 0;
        m_mask     = (d == 0) ? 32'hFFFF : 32'hF;
        cyc        = 0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opc        = rnd_opc();
        q.delete();
        #1;
        e = base(3'd0);
        check_obs("reset", get_obs(), e);
        @(negedge clk);
        if (d == 0) rst_n0 = 1'b1;
        else        rst_n1 = 1'b1;
        #1;
        check_obs("post_release", get_obs(), e);
    endtask

    function automatic int pick_wait(input int w);
        return ($urandom_range(0, 14) == 0) ? w : $urandom_range(0, w - 1);
    endfunction

    function automatic logic [6:0] illegal_op();
        logic [6:0] op;
        for (int k = 0; k < 100; k++) begin
            op = rnd_opc();
            if (classify(op) == 4) return op;
        end
        return 7'b1111111;
    endfunction

    initial begin
        bit         tr;
        logic [6:0] op;
        obs_t       e;
        // NOTE: bench inputs are driven with blocking assignments, away from the sampling edge.
        rst_n0     = 1'b0;
        rst_n1     = 1'b0;
        opc        = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;

        do_reset(0);
        model_instr(7'b0110011, 0, 0, tr); run_n(q.size());   // add, zero wait
        model_instr(7'b0000011, 0, 3, tr); run_n(q.size());   // lw, 3 data waits
        model_instr(7'b0100011, 0, 0, tr); run_n(q.size());   // sw, immediate
        model_instr(7'b0010011, 2, 0, tr); run_n(q.size());   // addi, fetch waits
        model_instr(7'b1111111, 0, 0, tr); run_n(q.size());   // illegal -> trap 01
        do_reset(0);
        model_instr(7'b0110011, W0, 0, tr); run_n(q.size());  // fetch timeout -> trap 10
        do_reset(0);
        model_instr(7'b0110011, W0 - 1, 0, tr); run_n(q.size()); // ready on last cycle
        model_instr(7'b0000011, 0, W0 - 1, tr); run_n(q.size());
        model_instr(7'b0100011, 1, W0, tr); run_n(q.size());  // data timeout -> trap 11
        do_reset(0);

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 8))
                0, 1:    op = 7'b0110011;
                2, 3:    op = 7'b0010011;
                4, 5:    op = 7'b0000011;
                6, 7:    op = 7'b0100011;
                default: op = illegal_op();
            endcase
            model_instr(op, pick_wait(W0), pick_wait(W0), tr);
            run_n(q.size());
            if (tr) do_reset(0);
        end

        do_reset(1);
        for (int n = 0; n < 16; n++) begin
            model_instr({3'b000, OPC_ADDI_PMU}, $urandom_range(0, 3), 0, tr);
            run_n(q.size());
        end
        model_instr({3'b000, OPC_LW_PMU}, 0, 10, tr);
        run_n(1);
        check_val("retired_wrap", int'(ret1), 0);
        run_n(3);
        check_val("mem_dmem_req", int'(dmem_req_w[1]), 1);
        #2;
        rst_n1 = 1'b0;
        #1;
        m_ret = 0;
        e = base(3'd0);
        check_obs("async_rst_mid_mem", get_obs(), e);
        q.delete();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
